// File: rtl/moore_run_detector_pkg.sv
// Shared constants and helpers for the run detector and later board designs.
package moore_run_detector_pkg;

    typedef enum logic {
        MODE_ONES  = 1'b0,
        MODE_ZEROS = 1'b1
    } mode_e;

    localparam int BOARD_CLK_HZ = 50_000_000;

    // Width needed to encode run lengths 0..run_len.
    function automatic int state_width(input int run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/moore_run_detector_if.sv
// Switch/pin inputs and LED/7-seg outputs of the run detector.
interface moore_run_detector_if #(
    parameter int SW    = 2,
    parameter int HIT_W = 8
) ();
    logic             w;
    logic             mode;
    logic             clr_hits;
    logic             tick;
    logic             sq_out;
    logic             z;
    logic             z_pulse;
    logic [SW-1:0]    tt_ht;
    logic [HIT_W-1:0] hits;

    modport master (
        output w, mode, clr_hits,
        input  tick, sq_out, z, z_pulse, tt_ht, hits
    );

    modport slave (
        input  w, mode, clr_hits,
        output tick, sq_out, z, z_pulse, tt_ht, hits
    );
endinterface

// File: rtl/moore_run_detector_tick_gen.sv
// Sample-tick divider: one-Clock enable every CLK_HZ/TICK_HZ cycles plus an LED square wave.
module tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic Clock,
    input  logic Resetn,
    output logic tick,
    output logic sq_out
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // tick is registered, so it lands in the cycle after cnt reaches DIV-1.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt    <= '0;
            tick   <= 1'b0;
            sq_out <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt    <= '0;
            tick   <= 1'b1;
            sq_out <= ~sq_out;
        end else begin
            cnt    <= cnt + 1'b1;
            tick   <= 1'b0;
        end
    end
endmodule

// File: rtl/moore_run_detector.sv
// Moore run detector: z asserts after RUN_LEN consecutive matching samples of w taken on slow ticks.
//  state     | meaning
//  S0        | no matching sample in the current run
//  Sk (0<k<N)| k consecutive matching samples
//  S_RUN_LEN | run complete, z=1 until a mismatching sample
module moore_run_detector
    import moore_run_detector_pkg::*;
#(
    parameter int CLK_HZ  = BOARD_CLK_HZ,
    parameter int TICK_HZ = 1,
    parameter int RUN_LEN = 2,
    parameter int HIT_W   = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    moore_run_detector_if.slave  bus
);
    localparam int SW = state_width(RUN_LEN);

    logic             tick;
    logic             sq_out;
    logic             w_meta;
    logic             w_s;
    logic             match;
    logic [SW-1:0]    state;
    logic [SW-1:0]    state_nxt;
    logic             z_pulse;
    logic             pulse_nxt;
    logic [HIT_W-1:0] hits;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .Clock  (Clock),
        .Resetn (Resetn),
        .tick   (tick),
        .sq_out (sq_out)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            w_meta <= 1'b0;
            w_s    <= 1'b0;
        end else begin
            w_meta <= bus.w;
            w_s    <= w_meta;
        end
    end

    assign match = (bus.mode == MODE_ONES) ? w_s : ~w_s;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= '0;
            z_pulse <= 1'b0;
        end else begin
            state   <= state_nxt;
            z_pulse <= pulse_nxt;
        end
    end

    // Out-of-range encodings fall into the mismatch branch and return to S0.
    always_comb begin
        state_nxt = state;
        pulse_nxt = 1'b0;
        if (tick) begin
            if (!match || state > SW'(RUN_LEN)) begin
                state_nxt = '0;
            end else if (state != SW'(RUN_LEN)) begin
                state_nxt = state + 1'b1;
                pulse_nxt = (state == SW'(RUN_LEN - 1));
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            hits <= '0;
        end else if (bus.clr_hits) begin
            hits <= '0;
        end else if (z_pulse && hits != {HIT_W{1'b1}}) begin
            hits <= hits + 1'b1;
        end
    end

    assign bus.tick    = tick;
    assign bus.sq_out  = sq_out;
    assign bus.z       = (state == SW'(RUN_LEN));
    assign bus.z_pulse = z_pulse;
    assign bus.tt_ht   = state;
    assign bus.hits    = hits;
endmodule
